prbs_gen_chk: RTL and testbench
===============================

PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

Interface
REQ-001 SHALL have parameter WIDTH, default 32, LFSR length; legal range 7..32.
REQ-002 SHALL have parameter TAPS, default 32'h80200003, feedback tap mask with bit k meaning state bit k is tapped; only bits [WIDTH-1:0] are used.
REQ-003 SHALL have parameter SEED, default 1, generator reset value; it must be nonzero in [WIDTH-1:0].
REQ-004 SHALL have parameter NCH, default 2, number of independent generator/checker channels; legal range 1..4.
REQ-005 SHALL have parameter ERRW, default 16, error counter width.
REQ-006 SHALL have parameter LOSS_THR, default 8, number of mismatches within one 32-cycle window that drops lock.
REQ-007 SHALL have port Clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port Rst, input, 1 bit, synchronous active-high reset.
REQ-009 SHALL have port En, input, 1 bit, advance enable shared by all channels.
REQ-010 SHALL have port InjErr, input, NCH bits, per-channel generator error inject.
REQ-011 SHALL have port ClrErr, input, NCH bits, per-channel error counter clear.
REQ-012 SHALL have port ChkIn, input, NCH bits, per-channel checker serial input.
REQ-013 SHALL have port GenOut, output, NCH bits, per-channel generator serial output.
REQ-014 SHALL have port Locked, output, NCH bits, per-channel checker lock status.
REQ-015 SHALL have port ErrPulse, output, NCH bits, one-cycle mismatch pulse per channel.
REQ-016 SHALL have port ErrCnt, output, NCH*ERRW bits; channel i occupies [i*ERRW +: ERRW].

Function
REQ-017 SHALL implement each generator as a Fibonacci LFSR G[WIDTH-1:0].
- Feedback: fb = XOR-reduce(G & TAPS).
- Next state: {G[WIDTH-2:0], fb}, taken only on cycles with En=1.
REQ-018 SHALL drive GenOut[i] = G[WIDTH-1] XOR InjErr[i] combinationally; InjErr SHALL NOT alter G.
REQ-019 SHALL reload SEED into G on the next En cycle if G is ever all-zero.
REQ-020 SHALL give each checker a state machine with states SEARCH and LOCK, a shift register C[WIDTH-1:0], a load counter, a 5-bit window counter and a bad-bit counter.
REQ-021 SHALL, in SEARCH on each En cycle, shift ChkIn into C[0] (C <= {C[WIDTH-2:0], ChkIn}) and increment the load counter; when the WIDTH-th bit is loaded, the state SHALL become LOCK on that edge.
REQ-022 SHALL, in LOCK on each En cycle, compute expected = XOR-reduce(C & TAPS) and shift expected (not ChkIn) into C, so that one corrupted bit counts exactly once.
REQ-023 SHALL, when ChkIn != expected in LOCK, register ErrPulse=1 for exactly the following cycle and increment ErrCnt in that same edge.
REQ-024 SHALL make ErrCnt saturate at 2^ERRW-1.
REQ-025 SHALL give ClrErr priority: ClrErr alone sets ErrCnt=0; ClrErr together with a mismatch in the same cycle sets ErrCnt=1.
REQ-026 SHALL run the window counter on LOCK En cycles and wrap 31->0; on the wrap the bad-bit counter SHALL clear, and a mismatch on the wrap cycle SHALL count as 1 in the new window.
REQ-027 SHALL, when the bad-bit counter reaches LOSS_THR, set the state to SEARCH on that edge and clear C, the load counter, the window counter and the bad-bit counter; ErrCnt SHALL be retained.
REQ-028 SHALL drive Locked = (state==LOCK) as a register; it rises the cycle after the WIDTH-th load and falls the cycle after the LOSS_THR-th mismatch.
REQ-029 SHALL, when En=0, hold all state and counters, count no mismatches, and drive ErrPulse=0; ClrErr SHALL still act.
REQ-030 SHALL keep channels fully independent; the only shared inputs are Clk, Rst and En.

Reset
REQ-031 SHALL, with Rst=1 at a clock edge, set G=SEED, C=0, all counters=0, state=SEARCH, Locked=0, ErrPulse=0 and ErrCnt=0 on all channels.
REQ-032 SHALL give Rst priority over En, InjErr and ClrErr; asserting Rst in LOCK returns to SEARCH on the next edge.

Verification
REQ-033 SHALL check: WIDTH=7, TAPS=7'h60, SEED=1, En=1 -> GenOut[0] period is exactly 127 cycles and G is never 0.
REQ-034 SHALL check: GenOut looped to ChkIn, WIDTH=7 -> Locked=1 on the 8th cycle after Rst release, and ErrCnt stays 0 over 2000 cycles.
REQ-035 SHALL check: while locked, InjErr[1] pulsed for 1 cycle -> ErrPulse[1] is high for exactly 1 cycle, ErrCnt ch1=1, Locked stays 1, and channel 0 is unaffected.
REQ-036 SHALL check: while locked, ChkIn = ~GenOut -> Locked falls the cycle after the 8th mismatch and ErrCnt=8.
REQ-037 SHALL check: ERRW=4, 20 single injects spaced 40 cycles apart -> ErrCnt=15 and Locked stays 1; then ClrErr coincident with an inject -> ErrCnt=1.
REQ-038 SHALL check: Rst for 1 cycle mid-lock, with En held 0 for 3 cycles around it -> Locked=0 and ErrCnt=0 next cycle; GenOut restarts from SEED when En resumes.

Source files
------------

// File: rtl/prbs_gen_chk.sv
// Multi-channel PRBS generator and self-synchronising checker.
// Each channel: Fibonacci LFSR source plus lock/loss tracking checker.
module prbs_gen_chk #(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] TAPS     = 32'h80200003,
  parameter logic [31:0] SEED     = 32'd1,
  parameter int          NCH      = 2,
  parameter int          ERRW     = 16,
  parameter int          LOSS_THR = 8
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                En,
  input  logic [NCH-1:0]      InjErr,
  input  logic [NCH-1:0]      ClrErr,
  input  logic [NCH-1:0]      ChkIn,
  output logic [NCH-1:0]      GenOut,
  output logic [NCH-1:0]      Locked,
  output logic [NCH-1:0]      ErrPulse,
  output logic [NCH*ERRW-1:0] ErrCnt
);

  localparam logic [WIDTH-1:0] TM = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SM = SEED[WIDTH-1:0];
  localparam int LDW = $clog2(WIDTH + 1);
  localparam int BW  = $clog2(LOSS_THR + 1);
  localparam logic [ERRW-1:0] CMAX = '1;

  typedef enum logic {
    SEARCH,
    LOCK
  } st_e;

  for (genvar i = 0; i < NCH; i++) begin : g_ch

    logic [WIDTH-1:0] g_q, g_d;

    // An all-zero state would lock up the LFSR, so reseed from it.
    always_comb begin
      g_d = g_q;
      if (En) begin
        if (g_q == '0) begin
          g_d = SM;
        end else begin
          g_d = {g_q[WIDTH-2:0], ^(g_q & TM)};
        end
      end
    end

    always_ff @(posedge Clk) begin
      if (Rst) begin
        g_q <= SM;
      end else begin
        g_q <= g_d;
      end
    end

    assign GenOut[i] = g_q[WIDTH-1] ^ InjErr[i];

    st_e              st_q, st_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [LDW-1:0]   ld_q, ld_d;
    logic [4:0]       win_q, win_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic [BW-1:0]    bad_n;
    logic             ep_q, ep_d;
    logic [ERRW-1:0]  cnt_q, cnt_d;
    logic             exp_b;
    logic             mm;

    always_comb begin
      st_d  = st_q;
      c_d   = c_q;
      ld_d  = ld_q;
      win_d = win_q;
      bad_d = bad_q;
      cnt_d = cnt_q;
      exp_b = ^(c_q & TM);
      mm    = En && (st_q == LOCK) && (ChkIn[i] != exp_b);
      ep_d  = mm;
      // A mismatch on the wrap cycle opens the new window at one.
      if (win_q == 5'd31) begin
        bad_n = BW'(mm);
      end else begin
        bad_n = bad_q + BW'(mm);
      end
      if (En) begin
        unique case (st_q)
          SEARCH: begin
            c_d  = {c_q[WIDTH-2:0], ChkIn[i]};
            ld_d = ld_q + LDW'(1);
            if (ld_q == LDW'(WIDTH - 1)) begin
              st_d = LOCK;
            end
          end
          LOCK: begin
            // Shift the prediction so a flipped bit is counted once.
            c_d   = {c_q[WIDTH-2:0], exp_b};
            win_d = win_q + 5'd1;
            bad_d = bad_n;
            if (bad_n == BW'(LOSS_THR)) begin
              st_d  = SEARCH;
              c_d   = '0;
              ld_d  = '0;
              win_d = '0;
              bad_d = '0;
            end
          end
          default: st_d = SEARCH;
        endcase
      end
      if (ClrErr[i]) begin
        cnt_d = ERRW'(mm);
      end else if (mm && (cnt_q != CMAX)) begin
        cnt_d = cnt_q + ERRW'(1);
      end
    end

    always_ff @(posedge Clk) begin
      if (Rst) begin
        st_q  <= SEARCH;
        c_q   <= '0;
        ld_q  <= '0;
        win_q <= '0;
        bad_q <= '0;
        ep_q  <= 1'b0;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        c_q   <= c_d;
        ld_q  <= ld_d;
        win_q <= win_d;
        bad_q <= bad_d;
        ep_q  <= ep_d;
        cnt_q <= cnt_d;
      end
    end

    assign Locked[i]   = (st_q == LOCK);
    assign ErrPulse[i] = ep_q;
    assign ErrCnt[i*ERRW +: ERRW] = cnt_q;

  end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Bench for prbs_gen_chk: 7-bit LFSR, two channels, 4-bit counters.
// Channel-0 output stream is scoreboarded against a reference LFSR.
module tb_prbs_gen_chk;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       En;
  logic [1:0] InjErr;
  logic [1:0] ClrErr;
  logic [1:0] ChkIn;
  logic [1:0] GenOut;
  logic [1:0] Locked;
  logic [1:0] ErrPulse;
  logic [7:0] ErrCnt;
  logic [1:0] inv;

  int nerr = 0;
  int nchk = 0;

  logic [6:0] mg;
  bit         exp_q[$];
  logic       bits[254];

  assign ChkIn = GenOut ^ inv;

  always #5 Clk = ~Clk;

  prbs_gen_chk #(
    .WIDTH   (7),
    .TAPS    (32'h60),
    .SEED    (32'd1),
    .NCH     (2),
    .ERRW    (4),
    .LOSS_THR(8)
  ) u_dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .En      (En),
    .InjErr  (InjErr),
    .ClrErr  (ClrErr),
    .ChkIn   (ChkIn),
    .GenOut  (GenOut),
    .Locked  (Locked),
    .ErrPulse(ErrPulse),
    .ErrCnt  (ErrCnt)
  );

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit b;
    if (Rst) begin
      mg = 7'd1;
    end else if (En) begin
      mg = (mg == 7'd0) ? 7'd1 : {mg[5:0], mg[6] ^ mg[5]};
    end
    exp_q.push_back(mg[6]);
    @(posedge Clk);
    #1;
    b = exp_q.pop_front();
    chk("gen0", int'(GenOut[0]), int'(b));
  endtask

  initial begin
    int p;
    int lost;
    int diffs;
    int ones;
    int zw;
    int z;
    Rst    = 1'b1;
    En     = 1'b0;
    InjErr = '0;
    ClrErr = '0;
    inv    = '0;
    tick();
    tick();
    chk("rst_lock", Locked, 0);
    chk("rst_pulse", ErrPulse, 0);
    chk("rst_cnt", ErrCnt, 0);

    Rst = 1'b0;
    En  = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("pre_lock", Locked, 0);
    tick();
    chk("lock8", Locked, 3);

    p    = 0;
    lost = 0;
    for (int k = 0; k < 254; k++) begin
      tick();
      bits[k] = GenOut[0];
      if (ErrPulse != 2'b00) p++;
      if (Locked != 2'b11) lost++;
    end
    diffs = 0;
    ones  = 0;
    zw    = 0;
    for (int k = 0; k < 127; k++) begin
      if (bits[k] != bits[k+127]) diffs++;
      if (bits[k]) ones++;
    end
    for (int k = 0; k < 248; k++) begin
      z = 1;
      for (int j = 0; j < 7; j++) if (bits[k+j]) z = 0;
      zw += z;
    end
    chk("period", diffs, 0);
    chk("ones", ones, 64);
    chk("nonzero", zw, 0);
    for (int k = 0; k < 1740; k++) begin
      tick();
      if (ErrPulse != 2'b00) p++;
      if (Locked != 2'b11) lost++;
    end
    chk("loop_pulses", p, 0);
    chk("loop_lost", lost, 0);
    chk("loop_cnt0", ErrCnt[3:0], 0);
    chk("loop_cnt1", ErrCnt[7:4], 0);

    InjErr = 2'b10;
    tick();
    InjErr = 2'b00;
    chk("inj_pulse", ErrPulse, 2);
    p = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      p += int'(ErrPulse[1]);
    end
    chk("inj_once", p, 0);
    chk("inj_cnt1", ErrCnt[7:4], 1);
    chk("inj_cnt0", ErrCnt[3:0], 0);
    chk("inj_lock", Locked, 3);

    ClrErr = 2'b10;
    tick();
    ClrErr = 2'b00;
    chk("clr", ErrCnt[7:4], 0);
    lost = 0;
    for (int n = 0; n < 20; n++) begin
      InjErr = 2'b10;
      tick();
      InjErr = 2'b00;
      for (int k = 0; k < 39; k++) begin
        tick();
        if (Locked != 2'b11) lost++;
      end
    end
    chk("sat", ErrCnt[7:4], 15);
    chk("sat_lost", lost, 0);
    chk("sat_cnt0", ErrCnt[3:0], 0);
    ClrErr = 2'b10;
    InjErr = 2'b10;
    tick();
    ClrErr = 2'b00;
    InjErr = 2'b00;
    chk("clr_inj", ErrCnt[7:4], 1);

    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("relock", Locked, 3);
    inv = 2'b01;
    p   = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      p += int'(ErrPulse[0]);
    end
    chk("inv_held", Locked, 3);
    chk("inv_pulses", p, 7);
    tick();
    chk("inv_drop", Locked, 2);
    chk("inv_cnt", ErrCnt[3:0], 8);
    inv = 2'b00;
    for (int k = 0; k < 7; k++) tick();
    chk("inv_relock", Locked, 3);
    chk("inv_keep", ErrCnt[3:0], 8);
    InjErr = 2'b10;
    tick();
    InjErr = 2'b00;
    tick();
    chk("ch1_cnt", ErrCnt[7:4], 1);

    En     = 1'b0;
    ClrErr = 2'b10;
    inv    = 2'b01;
    tick();
    ClrErr = 2'b00;
    chk("hold_lock", Locked, 3);
    chk("hold_pulse", ErrPulse, 0);
    chk("hold_clr", ErrCnt, 8'h08);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    inv = 2'b00;
    chk("mid_rst_lock", Locked, 0);
    chk("mid_rst_cnt", ErrCnt, 0);
    chk("mid_rst_gen", GenOut[0], 0);
    tick();
    chk("post_hold", Locked, 0);
    En = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("seed5", GenOut[0], 0);
    tick();
    chk("seed6", GenOut[0], 1);
    tick();
    chk("relock2", Locked, 3);
    for (int k = 0; k < 40; k++) tick();
    chk("final_cnt", ErrCnt, 0);
    chk("final_lock", Locked, 3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
